// File: rtl/mtr_ramp_ctrl_pkg.sv
// Shared types and helpers for the motor ramp controller and its per-side channels.
package mtr_ctrl_pkg;

  localparam int DUTY_W = 12;
  localparam logic signed [DUTY_W-1:0] DUTY_MAX = 12'sd2047;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    ESTOP
  } state_t;

  // -2048 has no positive twin on the driver side, so it is pulled in to -2047.
  function automatic logic signed [DUTY_W-1:0] clamp_duty(input logic signed [DUTY_W-1:0] v);
    return (v < -DUTY_MAX) ? -DUTY_MAX : v;
  endfunction

endpackage

// File: rtl/mtr_ramp_ctrl_chan.sv
// One side of the ramp: duty register, reversal dwell counter and last-direction memory.
module mtr_ramp_chan
  import mtr_ctrl_pkg::*;
#(
  parameter int STEP       = 16,
  parameter int DEAD_TICKS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tick,
  input  logic signed [DUTY_W-1:0] i_eff_tgt,
  input  logic                     i_force_zero,
  output logic signed [DUTY_W-1:0] o_duty
);

  localparam int DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam logic [DW-1:0] DEAD_LIM = DW'(DEAD_TICKS);
  localparam logic signed [DUTY_W:0] STEP_S = (DUTY_W + 1)'(STEP);

  logic signed [DUTY_W-1:0] r_duty;
  logic [DW-1:0]            r_dead;
  logic                     r_dir_vld;
  logic                     r_dir_neg;

  logic signed [DUTY_W:0]   w_d, w_t, w_aim, w_diff, w_mag;
  logic signed [DUTY_W-1:0] w_lim, w_next;
  logic                     w_oppose, w_dwell;

  always_comb begin
    w_d      = {r_duty[DUTY_W-1], r_duty};
    w_t      = {i_eff_tgt[DUTY_W-1], i_eff_tgt};
    w_oppose = (w_d != '0) && (w_t[DUTY_W] != w_d[DUTY_W]);
    w_dwell  = (w_d == '0) && (w_t != '0) && r_dir_vld &&
               (w_t[DUTY_W] != r_dir_neg) && (r_dead < DEAD_LIM);
    // Opposing target: head for zero first so a reversal never crosses zero in one tick.
    w_aim    = w_oppose ? '0 : w_t;
    w_diff   = w_aim - w_d;
    w_mag    = w_diff[DUTY_W] ? -w_diff : w_diff;
    w_lim    = (w_mag > STEP_S) ? STEP_S[DUTY_W-1:0] : w_mag[DUTY_W-1:0];
    w_next   = w_diff[DUTY_W] ? (r_duty - w_lim) : (r_duty + w_lim);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_duty    <= '0;
      r_dead    <= '0;
      r_dir_vld <= 1'b0;
      r_dir_neg <= 1'b0;
    end else begin
      if (i_force_zero) begin
        r_duty <= '0;
        r_dead <= '0;
      end else if (i_tick) begin
        if (w_dwell) r_dead <= r_dead + DW'(1);
        else         r_duty <= w_next;
      end
      if (r_duty != '0) begin
        r_dead    <= '0;
        r_dir_vld <= 1'b1;
        r_dir_neg <= r_duty[DUTY_W-1];
      end
    end
  end

  assign o_duty = r_duty;

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate / sequencing controller feeding the dual-motor PWM driver.
// state | meaning
// IDLE  | both duties held at 0, waiting for en
// RUN   | ramping toward the conditioned targets
// STOP  | ramping toward 0, returns to IDLE once both sides reach 0
// ESTOP | duties forced to 0, leaves only when estop and en are both low
module mtr_ramp_ctrl
  import mtr_ctrl_pkg::*;
#(
  parameter int RAMP_DIV   = 1024,
  parameter int STEP       = 16,
  parameter int DEAD_TICKS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_estop,
  input  logic signed [DUTY_W-1:0] i_lft_tgt,
  input  logic signed [DUTY_W-1:0] i_rght_tgt,
  output logic signed [DUTY_W-1:0] o_lft_duty,
  output logic signed [DUTY_W-1:0] o_rght_duty,
  output logic                     o_at_tgt,
  output logic                     o_busy
);

  localparam int PW = $clog2(RAMP_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  state_t                   r_state;
  logic [PW-1:0]            r_presc;
  logic                     r_at_tgt;
  logic                     r_busy;

  logic                     w_tick, w_force_zero, w_match;
  logic signed [DUTY_W-1:0] w_lft_eff, w_rght_eff, w_lft_duty, w_rght_duty;

  assign w_tick       = (r_presc == PRESC_LAST) && (r_state != ESTOP);
  assign w_force_zero = i_estop || (r_state == ESTOP);
  assign w_lft_eff    = (r_state == RUN) ? clamp_duty(i_lft_tgt)  : '0;
  assign w_rght_eff   = (r_state == RUN) ? clamp_duty(i_rght_tgt) : '0;
  assign w_match      = (w_lft_duty == w_lft_eff) && (w_rght_duty == w_rght_eff);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_at_tgt <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_at_tgt <= w_match;
      r_busy   <= ((r_state == RUN) || (r_state == STOP)) && !w_match;
      if (w_force_zero || (r_presc == PRESC_LAST)) r_presc <= '0;
      else                                         r_presc <= r_presc + PW'(1);
      if (i_estop) begin
        r_state <= ESTOP;
      end else begin
        case (r_state)
          IDLE:    if (i_en) r_state <= RUN;
          RUN:     if (!i_en) r_state <= STOP;
          STOP: begin
            if (i_en)                                           r_state <= RUN;
            else if ((w_lft_duty == '0) && (w_rght_duty == '0)) r_state <= IDLE;
          end
          ESTOP:   if (!i_en) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  mtr_ramp_chan #(.STEP(STEP), .DEAD_TICKS(DEAD_TICKS)) u_lft (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (w_tick),
    .i_eff_tgt    (w_lft_eff),
    .i_force_zero (w_force_zero),
    .o_duty       (w_lft_duty)
  );

  mtr_ramp_chan #(.STEP(STEP), .DEAD_TICKS(DEAD_TICKS)) u_rght (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (w_tick),
    .i_eff_tgt    (w_rght_eff),
    .i_force_zero (w_force_zero),
    .o_duty       (w_rght_duty)
  );

  assign o_lft_duty  = w_lft_duty;
  assign o_rght_duty = w_rght_duty;
  assign o_at_tgt    = r_at_tgt;
  assign o_busy      = r_busy;

endmodule
